// File: rtl/weighted_center_of_mass.sv
`timescale 1ns/1ps
// weighted_center_of_mass
//   Computes the mass-weighted mean position (x, y) of NUM_NODES signed nodes.
//   Sums are accumulated one node per cycle. Two restoring dividers, one for x
//   and one for y, then run in parallel and produce one quotient bit per cycle.
//
//   Optional build macro COM_ROUND_EN: round to nearest (halves away from zero)
//   instead of truncating toward zero. Latency and ports are identical in both
//   builds.
//
// Ports
//   clk_in        : clock, rising edge
//   rst_in        : asynchronous active-low reset
//   valid_in      : request strobe, sampled only while idle
//   nodes_x_in    : packed signed x coordinates, node i at [i*POSITION_SIZE +: POSITION_SIZE]
//   nodes_y_in    : packed signed y coordinates, same packing
//   masses_in     : packed unsigned masses, node i at [i*MASS_SIZE +: MASS_SIZE]
//   com_x_out     : signed weighted mean of x
//   com_y_out     : signed weighted mean of y
//   valid_out     : one-cycle result strobe
//   busy_out      : high while a request is in flight
//   zero_mass_out : last result had total mass 0
module weighted_center_of_mass #(
  parameter int POSITION_SIZE = 8,
  parameter int NUM_NODES     = 4,
  parameter int MASS_SIZE     = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               valid_in,
  input  logic [NUM_NODES*POSITION_SIZE-1:0] nodes_x_in,
  input  logic [NUM_NODES*POSITION_SIZE-1:0] nodes_y_in,
  input  logic [NUM_NODES*MASS_SIZE-1:0]     masses_in,
  output logic [POSITION_SIZE-1:0]           com_x_out,
  output logic [POSITION_SIZE-1:0]           com_y_out,
  output logic                               valid_out,
  output logic                               busy_out,
  output logic                               zero_mass_out
);

  localparam int ACC_W = POSITION_SIZE + MASS_SIZE + $clog2(NUM_NODES);
  localparam int QW    = ACC_W + 1;
  localparam int IDX_W = $clog2(NUM_NODES);
  localparam int CNT_W = $clog2(QW);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                           state_q;
  logic signed [POSITION_SIZE-1:0]  x_q [NUM_NODES];
  logic signed [POSITION_SIZE-1:0]  y_q [NUM_NODES];
  logic        [MASS_SIZE-1:0]      m_q [NUM_NODES];
  logic        [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]          sum_mx_q, sum_my_q;
  logic        [ACC_W-1:0]          sum_m_q;
  logic        [QW-1:0]             dvd_x_q, dvd_y_q;
  logic        [ACC_W-1:0]          rem_x_q, rem_y_q;
  logic        [ACC_W-1:0]          div_q;
  logic                             neg_x_q, neg_y_q;
  logic        [CNT_W-1:0]          cnt_q;
  logic        [POSITION_SIZE-1:0]  com_x_q, com_y_q;
  logic                             valid_q, busy_q, zero_q;

  logic signed [ACC_W-1:0]          m_ext, x_ext, y_ext;
  logic signed [ACC_W-1:0]          sum_mx_d, sum_my_d;
  logic        [ACC_W-1:0]          sum_m_d;
  logic signed [ACC_W-1:0]          abs_x, abs_y;
  logic        [QW-1:0]             mag_x, mag_y;
  logic        [QW-1:0]             rsh_x, rsh_y, dif_x, dif_y;
  logic                             ge_x, ge_y;
  logic        [ACC_W-1:0]          rem_x_d, rem_y_d;
  logic        [POSITION_SIZE-1:0]  qx, qy, com_x_d, com_y_d;

  always_comb begin
    m_ext    = signed'(ACC_W'(m_q[idx_q]));
    x_ext    = ACC_W'(x_q[idx_q]);
    y_ext    = ACC_W'(y_q[idx_q]);
    sum_mx_d = sum_mx_q + m_ext * x_ext;
    sum_my_d = sum_my_q + m_ext * y_ext;
    sum_m_d  = sum_m_q + ACC_W'(m_q[idx_q]);

    // Dividers are loaded from the final sums on the last accumulate edge,
    // so no extra set-up cycle is spent between ACCUM and DIVIDE.
    abs_x = sum_mx_d[ACC_W-1] ? -sum_mx_d : sum_mx_d;
    abs_y = sum_my_d[ACC_W-1] ? -sum_my_d : sum_my_d;
    mag_x = {1'b0, abs_x};
    mag_y = {1'b0, abs_y};
`ifdef COM_ROUND_EN
    mag_x = mag_x + QW'(sum_m_d >> 1);
    mag_y = mag_y + QW'(sum_m_d >> 1);
`else
`endif

    // One restoring step: the dividend register shifts its MSB into the
    // remainder and the quotient bit into its LSB.
    rsh_x   = {rem_x_q, dvd_x_q[QW-1]};
    rsh_y   = {rem_y_q, dvd_y_q[QW-1]};
    ge_x    = rsh_x >= {1'b0, div_q};
    ge_y    = rsh_y >= {1'b0, div_q};
    dif_x   = rsh_x - {1'b0, div_q};
    dif_y   = rsh_y - {1'b0, div_q};
    rem_x_d = ge_x ? dif_x[ACC_W-1:0] : rsh_x[ACC_W-1:0];
    rem_y_d = ge_y ? dif_y[ACC_W-1:0] : rsh_y[ACC_W-1:0];

    // Negating only the low bits gives the same low bits as negating the
    // full quotient.
    qx      = dvd_x_q[POSITION_SIZE-1:0];
    qy      = dvd_y_q[POSITION_SIZE-1:0];
    com_x_d = neg_x_q ? -qx : qx;
    com_y_d = neg_y_q ? -qy : qy;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      for (int unsigned i = 0; i < NUM_NODES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        m_q[i] <= '0;
      end
      idx_q    <= '0;
      sum_mx_q <= '0;
      sum_my_q <= '0;
      sum_m_q  <= '0;
      dvd_x_q  <= '0;
      dvd_y_q  <= '0;
      rem_x_q  <= '0;
      rem_y_q  <= '0;
      div_q    <= '0;
      neg_x_q  <= 1'b0;
      neg_y_q  <= 1'b0;
      cnt_q    <= '0;
      com_x_q  <= '0;
      com_y_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (valid_in) begin
            for (int unsigned i = 0; i < NUM_NODES; i++) begin
              x_q[i] <= nodes_x_in[i*POSITION_SIZE +: POSITION_SIZE];
              y_q[i] <= nodes_y_in[i*POSITION_SIZE +: POSITION_SIZE];
              m_q[i] <= masses_in[i*MASS_SIZE +: MASS_SIZE];
            end
            idx_q    <= '0;
            sum_mx_q <= '0;
            sum_my_q <= '0;
            sum_m_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ACCUM;
          end
        end

        ACCUM: begin
          sum_mx_q <= sum_mx_d;
          sum_my_q <= sum_my_d;
          sum_m_q  <= sum_m_d;
          idx_q    <= idx_q + 1'b1;
          if (idx_q == IDX_W'(NUM_NODES - 1)) begin
            if (sum_m_d != '0) begin
              dvd_x_q <= mag_x;
              dvd_y_q <= mag_y;
              rem_x_q <= '0;
              rem_y_q <= '0;
              div_q   <= sum_m_d;
              neg_x_q <= sum_mx_d[ACC_W-1];
              neg_y_q <= sum_my_d[ACC_W-1];
              cnt_q   <= '0;
              state_q <= DIVIDE;
            end else begin
              state_q <= DONE;
            end
          end
        end

        DIVIDE: begin
          dvd_x_q <= {dvd_x_q[QW-2:0], ge_x};
          dvd_y_q <= {dvd_y_q[QW-2:0], ge_y};
          rem_x_q <= rem_x_d;
          rem_y_q <= rem_y_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(QW - 1)) state_q <= DONE;
        end

        DONE: begin
          if (sum_m_q == '0) begin
            com_x_q <= '0;
            com_y_q <= '0;
            zero_q  <= 1'b1;
          end else begin
            com_x_q <= com_x_d;
            com_y_q <= com_y_d;
            zero_q  <= 1'b0;
          end
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign com_x_out     = com_x_q;
  assign com_y_out     = com_y_q;
  assign valid_out     = valid_q;
  assign busy_out      = busy_q;
  assign zero_mass_out = zero_q;

endmodule

// File: tb/tb_weighted_center_of_mass.sv
`timescale 1ns/1ps
// Self-checking bench for weighted_center_of_mass (default parameters).
// Expected results come from integer arithmetic over the node lists.
module tb_weighted_center_of_mass;

  localparam int P     = 8;
  localparam int N     = 4;
  localparam int M     = 8;
  localparam int ACC_W = P + M + $clog2(N);
  localparam int QW    = ACC_W + 1;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             valid_in = 1'b0;
  logic [N*P-1:0]   nodes_x_in = '0;
  logic [N*P-1:0]   nodes_y_in = '0;
  logic [N*M-1:0]   masses_in = '0;
  logic [P-1:0]     com_x_out, com_y_out;
  logic             valid_out, busy_out, zero_mass_out;

  int checks = 0;
  int errors = 0;

  weighted_center_of_mass #(
    .POSITION_SIZE(P),
    .NUM_NODES    (N),
    .MASS_SIZE    (M)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .nodes_x_in   (nodes_x_in),
    .nodes_y_in   (nodes_y_in),
    .masses_in    (masses_in),
    .com_x_out    (com_x_out),
    .com_y_out    (com_y_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out),
    .zero_mass_out(zero_mass_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int mean_div(input int s, input int d);
    int mag, q;
`ifdef COM_ROUND_EN
    mag = (s < 0) ? -s : s;
    q   = (mag + d / 2) / d;
    return (s < 0) ? -q : q;
`else
    mag = 0;
    q   = s / d;
    return q + mag;
`endif
  endfunction

  function automatic void model(input logic [N*P-1:0] xv, input logic [N*P-1:0] yv,
                                input logic [N*M-1:0] mv,
                                output logic [P-1:0] ex, output logic [P-1:0] ey,
                                output logic ez);
    int smx, smy, sm, xi, yi, mi;
    smx = 0; smy = 0; sm = 0;
    for (int i = 0; i < N; i++) begin
      xi  = int'($signed(xv[i*P +: P]));
      yi  = int'($signed(yv[i*P +: P]));
      mi  = int'(mv[i*M +: M]);
      smx += mi * xi;
      smy += mi * yi;
      sm  += mi;
    end
    if (sm == 0) begin
      ex = '0; ey = '0; ez = 1'b1;
    end else begin
      ex = P'(mean_div(smx, sm));
      ey = P'(mean_div(smy, sm));
      ez = 1'b0;
    end
  endfunction

  // Drives one request (caller is away from a rising edge), checks the
  // acceptance, latency and result. If inject > 0, a second request with
  // different data is presented so that it is sampled 'inject' edges after
  // the accepting edge.
  task automatic do_request(input logic [N*P-1:0] xv, input logic [N*P-1:0] yv,
                            input logic [N*M-1:0] mv, input int inject, input string tag);
    logic [P-1:0] ex, ey;
    logic ez;
    int exp_lat, k;
    bit seen;
    model(xv, yv, mv, ex, ey, ez);
    exp_lat = ez ? N + 1 : N + QW + 1;
    nodes_x_in = xv; nodes_y_in = yv; masses_in = mv; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    checks++;
    if (busy_out !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: busy_out=%b expected 1", tag, busy_out);
    end
    k = 0; seen = 0;
    while (!seen && k < 200) begin
      @(posedge clk_in); k++; #1;
      if (valid_out === 1'b1) seen = 1;
      else if (k + 1 == inject) begin
        valid_in = 1'b1; nodes_x_in = ~xv; nodes_y_in = yv ^ 32'h5A5A5A5A; masses_in = ~mv;
      end else valid_in = 1'b0;
    end
    valid_in = 1'b0;
    checks++;
    if (!seen || k != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", tag, k, seen, exp_lat);
    end
    checks++;
    if (com_x_out !== ex || com_y_out !== ey || zero_mass_out !== ez) begin
      errors++;
      $display("FAIL %s result: x=%0d y=%0d zero=%b expected x=%0d y=%0d zero=%b", tag,
               $signed(com_x_out), $signed(com_y_out), zero_mass_out,
               $signed(ex), $signed(ey), ez);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (com_x_out !== '0 || com_y_out !== '0 || valid_out !== 1'b0 ||
        busy_out !== 1'b0 || zero_mass_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: x=%h y=%h v=%b b=%b z=%b expected all 0",
               com_x_out, com_y_out, valid_out, busy_out, zero_mass_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_directed();
    do_request({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'hFC}}, {4{8'd1}}, 0, "equal_mass");
    checks++;
    if ($signed(com_x_out) !== 8'sd25 || $signed(com_y_out) !== -8'sd4) begin
      errors++;
      $display("FAIL equal_mass_const: x=%0d y=%0d expected 25 -4",
               $signed(com_x_out), $signed(com_y_out));
    end
    do_request({8'd100, 8'd100, 8'd8, 8'd0}, {8'd90, 8'd90, 8'd0, 8'hF8},
               {8'd0, 8'd0, 8'd1, 8'd3}, 0, "weighted");
    do_request({8'd50, 8'd0, 8'd1, 8'd1}, {8'd50, 8'd0, 8'hFF, 8'hFF},
               {8'd0, 8'd1, 8'd1, 8'd1}, 0, "rounding");
    do_request({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, '0, 0, "zero_mass");
    do_request({4{8'h80}}, {4{8'h7F}}, {4{8'hFF}}, 0, "extreme");
    do_request({8'h80, 8'h7F, 8'h80, 8'h7F}, {8'd3, 8'h81, 8'd9, 8'hF0},
               {8'hFF, 8'h01, 8'h00, 8'hFE}, 0, "mixed_extreme");
  endtask

  task automatic test_random();
    logic [N*P-1:0] xv, yv;
    logic [N*M-1:0] mv;
    for (int i = 0; i < 30; i++) begin
      xv = $urandom(); yv = $urandom(); mv = $urandom();
      if ($urandom_range(0, 5) == 0) mv = '0;
      else if ($urandom_range(0, 3) == 0) mv = mv & 32'h0000FF00;
      do_request(xv, yv, mv, 0, "random");
    end
  endtask

  task automatic test_ignore_busy();
    int stray;
    do_request({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'hFC}}, {4{8'd1}}, 3, "ignore_busy");
    stray = 0;
    repeat (30) begin
      @(posedge clk_in); #1;
      if (valid_out === 1'b1 || busy_out === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL ignore_busy_no_queue: %0d active cycles expected 0", stray);
    end
  endtask

  task automatic test_hold();
    logic [P-1:0] hx, hy;
    logic hz;
    int moved;
    do_request({8'd7, 8'hF9, 8'd20, 8'd3}, {8'd1, 8'd2, 8'h80, 8'd4},
               {8'd9, 8'd2, 8'd5, 8'd17}, 0, "hold_src");
    hx = com_x_out; hy = com_y_out; hz = zero_mass_out;
    moved = 0;
    repeat (8) begin
      nodes_x_in = $urandom(); nodes_y_in = $urandom(); masses_in = $urandom();
      @(posedge clk_in); #1;
      if (com_x_out !== hx || com_y_out !== hy || zero_mass_out !== hz || valid_out !== 1'b0)
        moved++;
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d cycles changed expected 0", moved);
    end
  endtask

  task automatic test_back_to_back();
    do_request({8'd1, 8'd2, 8'd3, 8'd4}, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4}, 0, "b2b_0");
    do_request({8'hF0, 8'd2, 8'd30, 8'd4}, {8'd40, 8'h83, 8'd2, 8'd1}, '0, 0, "b2b_1");
    do_request({8'h90, 8'd60, 8'd3, 8'd77}, {8'd4, 8'd3, 8'hC2, 8'd1}, {8'd8, 8'd0, 8'd200, 8'd4}, 0, "b2b_2");
  endtask

  task automatic test_reset_mid_divide();
    int stray;
    do_request({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'hFC}}, {4{8'd1}}, 0, "pre_abort");
    @(negedge clk_in);
    nodes_x_in = {8'd90, 8'd90, 8'd90, 8'd90}; masses_in = {4{8'd3}}; valid_in = 1'b1;
    @(posedge clk_in); #1; valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checks++;
    if (com_x_out !== '0 || com_y_out !== '0 || valid_out !== 1'b0 ||
        busy_out !== 1'b0 || zero_mass_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: x=%h y=%h v=%b b=%b z=%b expected all 0",
               com_x_out, com_y_out, valid_out, busy_out, zero_mass_out);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    stray = 0;
    repeat (40) begin
      @(posedge clk_in); #1;
      if (valid_out === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_no_valid: %0d strobes expected 0", stray);
    end
    // Abort again, then present the request on the first edge after release.
    @(negedge clk_in);
    valid_in = 1'b1;
    @(posedge clk_in); #1; valid_in = 1'b0;
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    do_request({8'd40, 8'd30, 8'd20, 8'd10}, {4{8'hFC}}, {4{8'd1}}, 0, "after_abort");
    checks++;
    if ($signed(com_x_out) !== 8'sd25 || $signed(com_y_out) !== -8'sd4) begin
      errors++;
      $display("FAIL after_abort_const: x=%0d y=%0d expected 25 -4",
               $signed(com_x_out), $signed(com_y_out));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_divide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
